// File: rtl/lcd_fetch_ctrl.sv
// lcd_fetch_ctrl: per-frame sequencer that flushes the lcdc pixel FIFO and refills it
// with framebuffer burst reads gated by FIFO free space.
module lcd_fetch_ctrl #(
    parameter int ADDR_W      = 20,
    parameter int FRAME_WORDS = 19200,
    parameter int BURST_LEN   = 8,
    parameter int FIFO_DEPTH  = 512,
    parameter int LVL_W       = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              frame_start,
    input  logic [ADDR_W-1:0] fb_base,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [4:0]        mem_len,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [47:0]       mem_rdata,
    output logic              fifo_flush,
    output logic              fifo_wr_en,
    output logic [47:0]       fifo_wr_data,
    input  logic [LVL_W-1:0]  fifo_level,
    input  logic              fifo_full,
    output logic              busy,
    output logic              frame_done,
    output logic              overrun_err
);
    localparam int RW = $clog2(FRAME_WORDS + 1);
    localparam int SW = LVL_W + 1;

    typedef enum logic [2:0] {IDLE, FLUSH, WAIT_SPACE, REQ, DATA, DONE} state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] addr, base_pend;
    logic [RW-1:0]     remaining, rem_nx;
    logic [4:0]        len, beats;
    logic              restart_pend, fs_ok, last_beat, space_ok;

    assign len       = (32'(remaining) >= BURST_LEN) ? 5'(BURST_LEN) : 5'(remaining);
    assign rem_nx    = remaining - RW'(len);
    assign space_ok  = SW'(fifo_level) + SW'(len) <= SW'(FIFO_DEPTH);
    assign last_beat = (state == DATA) && mem_rvalid && (beats + 5'd1 == len);

    assign mem_req    = state == REQ;
    assign mem_addr   = mem_req ? addr : '0;
    assign mem_len    = mem_req ? len : '0;
    assign fifo_flush = state == FLUSH;
    assign frame_done = state == DONE;
    assign busy       = state != IDLE;

    always_comb begin
        state_nx = state;
        fs_ok    = 1'b0;
        case (state)
            IDLE: begin
                fs_ok    = frame_start && enable;
                state_nx = fs_ok ? FLUSH : IDLE;
            end
            FLUSH: state_nx = WAIT_SPACE;
            WAIT_SPACE: begin
                fs_ok    = frame_start;
                state_nx = frame_start ? FLUSH : !enable ? IDLE : space_ok ? REQ : WAIT_SPACE;
            end
            REQ: begin
                fs_ok    = frame_start;
                state_nx = frame_start ? FLUSH : mem_gnt ? DATA : REQ;
            end
            // a restart here only takes effect once the granted burst has drained
            DATA: begin
                fs_ok    = frame_start;
                state_nx = !last_beat ? DATA : (restart_pend || frame_start) ? FLUSH :
                           !enable ? IDLE : (rem_nx == '0) ? DONE : WAIT_SPACE;
            end
            DONE: begin
                fs_ok    = frame_start;
                state_nx = frame_start ? FLUSH : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            addr         <= '0;
            base_pend    <= '0;
            remaining    <= '0;
            beats        <= '0;
            restart_pend <= 1'b0;
            fifo_wr_en   <= 1'b0;
            fifo_wr_data <= '0;
            overrun_err  <= 1'b0;
        end else begin
            state        <= state_nx;
            restart_pend <= (state == DATA) && (state_nx == DATA) && (restart_pend || frame_start);
            beats        <= (state != DATA) ? 5'd0 : mem_rvalid ? beats + 5'd1 : beats;
            fifo_wr_en   <= (state == DATA) && mem_rvalid && !restart_pend;
            if (fs_ok)
                base_pend <= fb_base;
            if (state_nx == FLUSH && state != FLUSH) begin
                addr      <= frame_start ? fb_base : base_pend;
                remaining <= RW'(FRAME_WORDS);
            end else if (last_beat) begin
                addr      <= addr + ADDR_W'(len);
                remaining <= rem_nx;
            end
            if ((state == DATA) && mem_rvalid && !restart_pend)
                fifo_wr_data <= mem_rdata;
            if (fs_ok)
                overrun_err <= 1'b0;
            else if ((state == DATA) && mem_rvalid && fifo_full && !restart_pend)
                overrun_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_lcd_fetch_ctrl.sv
// tb_lcd_fetch_ctrl: randomized scenarios against a simple arbiter/memory model and
// an address/length schedule derived directly from the frame arithmetic.
module tb_lcd_fetch_ctrl;
    localparam int AW = 20, FW = 20, BL = 8, FD = 512, LW = 10;

    logic          clk = 1'b0, rst_n = 1'b0, enable = 1'b0, frame_start = 1'b0;
    logic [AW-1:0] fb_base = '0;
    logic          mem_req, mem_gnt = 1'b0, mem_rvalid = 1'b0;
    logic [AW-1:0] mem_addr;
    logic [4:0]    mem_len;
    logic [47:0]   mem_rdata = '0;
    logic          fifo_flush, fifo_wr_en, fifo_full = 1'b0;
    logic [47:0]   fifo_wr_data;
    logic [LW-1:0] fifo_level = '0;
    logic          busy, frame_done, overrun_err;

    always #5 clk = ~clk;

    lcd_fetch_ctrl #(.ADDR_W(AW), .FRAME_WORDS(FW), .BURST_LEN(BL), .FIFO_DEPTH(FD), .LVL_W(LW)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .frame_start(frame_start), .fb_base(fb_base),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_len(mem_len), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .fifo_flush(fifo_flush),
        .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data), .fifo_level(fifo_level),
        .fifo_full(fifo_full), .busy(busy), .frame_done(frame_done), .overrun_err(overrun_err)
    );

    wire [78:0] outs = {mem_req, mem_addr, mem_len, fifo_flush, fifo_wr_en, fifo_wr_data,
                        busy, frame_done, overrun_err};

    typedef struct {logic [AW-1:0] addr; int len;} req_t;
    req_t        got_req[$];
    logic [47:0] got_wr[$], sent[$];
    int          checks = 0, errors = 0;
    int          flush_n, done_n, req_seen, req_wait, beats_left, gnt_dly;
    bit          gnt_en, pause, gap_mode;

    // One clock of observation plus arbiter/memory behaviour, all at the falling edge.
    task automatic cycle();
        logic [63:0] r;
        @(negedge clk);
        if (fifo_wr_en) got_wr.push_back(fifo_wr_data);
        if (fifo_flush) flush_n++;
        if (frame_done) done_n++;
        if (mem_req) req_seen++;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        if (!mem_req) req_wait = 0;
        if (mem_req && gnt_en) begin
            if (req_wait >= gnt_dly) begin
                mem_gnt = 1'b1;
                got_req.push_back('{mem_addr, int'(mem_len)});
                beats_left = int'(mem_len);
                req_wait   = 0;
            end else req_wait++;
        end else if (beats_left > 0 && !pause && (!gap_mode || $urandom_range(0, 2) != 0)) begin
            r          = {$urandom, $urandom};
            mem_rdata  = r[47:0];
            mem_rvalid = 1'b1;
            sent.push_back(r[47:0]);
            beats_left--;
        end
    endtask

    task automatic clear_logs();
        got_req.delete(); got_wr.delete(); sent.delete();
        flush_n = 0; done_n = 0; req_seen = 0; req_wait = 0; beats_left = 0;
        pause = 0; gap_mode = 0; gnt_en = 1; gnt_dly = 1;
    endtask

    task automatic start_frame(input logic [AW-1:0] b);
        fb_base     = b;
        frame_start = 1'b1;
        cycle();
        frame_start = 1'b0;
    endtask

    task automatic run_to_idle(input int maxc, output bit ok);
        ok = 0;
        for (int i = 0; i < maxc; i++) begin
            cycle();
            if (!busy) begin ok = 1; break; end
        end
    endtask

    task automatic wait_sent(input int n, output bit ok);
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            cycle();
            if (sent.size() >= n) begin ok = 1; break; end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; beats_left = 0; mem_gnt = 1'b0; mem_rvalid = 1'b0; frame_start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Expected bursts: consecutive BURST_LEN chunks of the frame, last one short, addresses mod 2^AW.
    function automatic int req_bad(input logic [AW-1:0] base);
        int n = 0, k = 0;
        for (int off = 0; off < FW; off += BL) begin
            int            l = (FW - off < BL) ? FW - off : BL;
            logic [AW-1:0] a = base + AW'(off);
            if (k >= got_req.size() || got_req[k].addr !== a || got_req[k].len != l) n++;
            k++;
        end
        if (got_req.size() != k) n++;
        return n;
    endfunction

    function automatic int wr_bad(input int n);
        int b = (got_wr.size() != n) ? 1 : 0;
        for (int i = 0; i < got_wr.size(); i++)
            if (i >= sent.size() || got_wr[i] !== sent[i]) b++;
        return b;
    endfunction

    task automatic test_reset();
        checks++;
        if (outs !== '0) begin errors++; $display("FAIL reset_hold outs=%h required 0", outs); end
        @(negedge clk);
        rst_n = 1'b1;
        clear_logs();
        repeat (2) cycle();
        checks++;
        if (outs !== '0) begin errors++; $display("FAIL reset_release outs=%h required 0", outs); end
    endtask

    task automatic test_basic_frame(input bit gap, input int dly);
        bit ok; int n; logic [AW-1:0] b = AW'($urandom);
        clear_logs();
        enable = 1'b1; gap_mode = gap; gnt_dly = dly;
        start_frame(b);
        run_to_idle(600, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL basic_timeout busy=%0b required 0", busy); end
        n = req_bad(b);
        checks++;
        if (n != 0) begin errors++; $display("FAIL basic_reqs bad=%0d got_n=%0d required 0 bad", n, got_req.size()); end
        n = wr_bad(FW);
        checks++;
        if (n != 0) begin errors++; $display("FAIL basic_writes bad=%0d got_n=%0d required %0d", n, got_wr.size(), FW); end
        checks++;
        if (done_n != 1 || flush_n != 1) begin
            errors++; $display("FAIL basic_pulses done=%0d flush=%0d required 1 1", done_n, flush_n);
        end
    endtask

    task automatic test_backpressure();
        bit ok; logic [AW-1:0] b = AW'($urandom);
        clear_logs();
        fifo_level = LW'(FD - 5);
        start_frame(b);
        repeat (20) cycle();
        checks++;
        if (req_seen != 0 || busy !== 1'b1) begin
            errors++; $display("FAIL bp_stall req_cycles=%0d busy=%0b required 0 1", req_seen, busy);
        end
        fifo_level = LW'(FD - 8);
        cycle();
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== b || mem_len !== 5'd8) begin
            errors++; $display("FAIL bp_release req=%0b addr=%h len=%0d required 1 %h 8", mem_req, mem_addr, mem_len, b);
        end
        fifo_level = '0;
        run_to_idle(300, ok);
        checks++;
        if (!ok || done_n != 1 || wr_bad(FW) != 0) begin
            errors++; $display("FAIL bp_finish ok=%0b done=%0d writes=%0d required 1 1 %0d", ok, done_n, got_wr.size(), FW);
        end
    endtask

    task automatic test_restart_data();
        bit ok; logic [AW-1:0] b = AW'($urandom), nb = AW'($urandom);
        clear_logs();
        gnt_dly = 0;
        start_frame(b);
        wait_sent(3, ok);
        pause = 1;
        cycle();
        fb_base = nb; frame_start = 1'b1;
        cycle();
        frame_start = 1'b0; pause = 0; gnt_en = 0;
        repeat (20) cycle();
        checks++;
        if (!ok || wr_bad(3) != 0) begin
            errors++; $display("FAIL rd_writes ok=%0b writes=%0d required 3 matching", ok, got_wr.size());
        end
        checks++;
        if (flush_n != 2 || done_n != 0 || sent.size() != BL) begin
            errors++; $display("FAIL rd_pulses flush=%0d done=%0d beats=%0d required 2 0 %0d", flush_n, done_n, sent.size(), BL);
        end
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== nb) begin
            errors++; $display("FAIL rd_newbase req=%0b addr=%h required 1 %h", mem_req, mem_addr, nb);
        end
    endtask

    task automatic test_restart_req();
        logic [AW-1:0] nb = AW'($urandom);
        fb_base = nb; frame_start = 1'b1;
        cycle();
        frame_start = 1'b0;
        checks++;
        if (mem_req !== 1'b0 || fifo_flush !== 1'b1) begin
            errors++; $display("FAIL rq_abort req=%0b flush=%0b required 0 1", mem_req, fifo_flush);
        end
        repeat (10) cycle();
        checks++;
        if (done_n != 0 || mem_req !== 1'b1 || mem_addr !== nb) begin
            errors++; $display("FAIL rq_newbase done=%0d req=%0b addr=%h required 0 1 %h", done_n, mem_req, mem_addr, nb);
        end
        do_reset();
    endtask

    task automatic test_overrun();
        bit ok, ok2;
        clear_logs();
        gap_mode = 1;
        start_frame(AW'($urandom));
        wait_sent(2, ok);
        fifo_full = 1'b1;
        cycle();
        fifo_full = 1'b0;
        checks++;
        if (!ok || overrun_err !== 1'b1) begin errors++; $display("FAIL ovr_set err=%0b required 1", overrun_err); end
        run_to_idle(600, ok2);
        checks++;
        if (!ok2 || overrun_err !== 1'b1 || wr_bad(FW) != 0 || done_n != 1) begin
            errors++; $display("FAIL ovr_hold err=%0b writes=%0d done=%0d required 1 %0d 1", overrun_err, got_wr.size(), done_n, FW);
        end
        start_frame(AW'($urandom));
        checks++;
        if (overrun_err !== 1'b0) begin errors++; $display("FAIL ovr_clear err=%0b required 0", overrun_err); end
        run_to_idle(600, ok2);
    endtask

    task automatic test_enable_drop();
        bit ok, ok2;
        clear_logs();
        gnt_dly = 0;
        start_frame(AW'($urandom));
        wait_sent(1, ok);
        enable = 1'b0;
        run_to_idle(100, ok2);
        checks++;
        if (!ok || !ok2 || got_req.size() != 1 || wr_bad(BL) != 0 || done_n != 0) begin
            errors++; $display("FAIL en_drop reqs=%0d writes=%0d done=%0d required 1 %0d 0", got_req.size(), got_wr.size(), done_n, BL);
        end
        clear_logs();
        beats_left = 3;
        repeat (5) cycle();
        checks++;
        if (got_wr.size() != 0 || busy !== 1'b0) begin
            errors++; $display("FAIL idle_rvalid writes=%0d busy=%0b required 0 0", got_wr.size(), busy);
        end
        enable = 1'b1;
    endtask

    task automatic test_wrap_reset();
        bit ok;
        logic [AW-1:0] b = AW'((1 << AW) - 4);
        clear_logs();
        start_frame(b);
        run_to_idle(300, ok);
        checks++;
        if (!ok || req_bad(b) != 0 || got_req.size() < 2 || got_req[1].addr !== AW'(4)) begin
            errors++; $display("FAIL wrap_addr reqs=%0d second=%h required 3 00004", got_req.size(),
                               (got_req.size() > 1) ? got_req[1].addr : AW'(0));
        end
        clear_logs();
        start_frame(AW'($urandom));
        wait_sent(2, ok);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (!ok || outs !== '0) begin errors++; $display("FAIL async_reset outs=%h required 0", outs); end
        beats_left = 0; mem_rvalid = 1'b0; mem_gnt = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) cycle();
        checks++;
        if (outs !== '0) begin errors++; $display("FAIL post_reset outs=%h required 0", outs); end
    endtask

    initial begin
        clear_logs();
        repeat (3) @(negedge clk);
        test_reset();
        test_basic_frame(1'b0, 1);
        test_basic_frame(1'b1, 0);
        test_basic_frame(1'b1, 2);
        test_backpressure();
        test_restart_data();
        test_restart_req();
        test_overrun();
        test_enable_drop();
        test_wrap_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/lcd_fetch_ctrl.md
Name: lcd_fetch_ctrl

Overview:
- Per-frame sequencer that fills the 48-bit pixel FIFO feeding lcdc from a framebuffer memory port.
- On each frame start it flushes the FIFO, then issues burst reads from fb_base upward, gated by FIFO free space, until FRAME_WORDS words have been written.
- Replaces the constant-colour FIFO stub at top level. Sits between the memory arbiter (req/gnt/rvalid) and the FIFO write side, in the clk_18 domain.

Parameters:
- ADDR_W, 20, word address width of the memory port.
- FRAME_WORDS, 19200, 48-bit words per frame (640x480 at 3 bpp).
- BURST_LEN, 8, maximum beats per memory request (1..16).
- FIFO_DEPTH, 512, FIFO capacity in words.
- LVL_W, 10, width of fifo_level (holds 0..FIFO_DEPTH).

Ports:
- clk  in  1  fetch clock (clk_18 domain).
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  fetch enable, level-sensitive.
- frame_start  in  1  one-cycle pulse, synchronous to clk, derived from FLM.
- fb_base  in  ADDR_W  framebuffer base word address; sampled on an accepted frame_start.
- mem_req  out  1  burst request.
- mem_addr  out  ADDR_W  burst start address; stable while mem_req=1.
- mem_len  out  5  beats in this burst (1..BURST_LEN); stable while mem_req=1.
- mem_gnt  in  1  request accepted (single cycle).
- mem_rvalid  in  1  read beat valid.
- mem_rdata  in  48  read beat data.
- fifo_flush  out  1  one-cycle FIFO clear.
- fifo_wr_en  out  1  FIFO write strobe.
- fifo_wr_data  out  48  FIFO write data.
- fifo_level  in  LVL_W  current FIFO fill level in words.
- fifo_full  in  1  FIFO full.
- busy  out  1  high in any state except IDLE.
- frame_done  out  1  one-cycle pulse after the last word of a frame is written.
- overrun_err  out  1  sticky overrun flag.

Behaviour:
- Reset: state=IDLE. All outputs are 0, including mem_addr and fifo_wr_data. Internal counters are cleared.
- States: IDLE, FLUSH, WAIT_SPACE, REQ, DATA, DONE.
- IDLE to FLUSH: on frame_start while enable=1.
  - Latch fb_base into addr.
  - Set remaining=FRAME_WORDS.
  - Clear overrun_err.
- FLUSH: fifo_flush=1 for exactly one cycle, then go to WAIT_SPACE.
- WAIT_SPACE:
  - len = min(BURST_LEN, remaining).
  - Go to REQ when fifo_level + len <= FIFO_DEPTH.
  - If enable=0, go to IDLE instead.
- REQ:
  - mem_req=1 with mem_addr=addr and mem_len=len, held until mem_gnt.
  - On mem_gnt, go to DATA. mem_req is 0 the following cycle.
  - A gnt in the same cycle as req is legal.
- DATA: each mem_rvalid produces one FIFO write, registered:
  - fifo_wr_en=1 and fifo_wr_data=mem_rdata on the next cycle (1-cycle latency).
  - Count beats until the count equals len.
  - On the final beat: addr += len (wraps modulo 2^ADDR_W) and remaining -= len.
  - Then go to DONE if remaining=0, otherwise to WAIT_SPACE.
- DONE: frame_done=1 for one cycle, then go to IDLE.
- Zero-gap bursts: back-to-back rvalid on every cycle must be sustained without dropping beats.
- frame_start outside IDLE (restart):
  - In WAIT_SPACE, REQ or DONE: abort immediately to FLUSH with a new base.
  - A pending mem_req is dropped without waiting for gnt. Arbiter rule: gnt is only honoured while req=1.
  - In DATA: set restart_pend. The remaining beats of the burst are consumed but not written (fifo_wr_en=0). Then go to FLUSH.
  - In FLUSH: ignored.
- enable=0 mid-frame:
  - An outstanding burst in DATA completes and its beats are written.
  - Then go to IDLE. No frame_done is issued.
- Overrun: mem_rvalid while fifo_full=1 sets overrun_err. The beat is still presented to the FIFO. overrun_err stays set until the next accepted frame_start or reset.
- Extra mem_rvalid in IDLE, WAIT_SPACE or REQ: ignored, no write.
- Reset mid-burst: immediate return to IDLE with all outputs 0. The memory side must tolerate the abandoned burst.
- busy=1 in every state except IDLE.

Test Plan:
- Basic frame: FRAME_WORDS=20, BURST_LEN=8, gnt 1 cycle after req, rvalid every cycle.
  - Expect 3 requests with (addr,len) = (base,8), (base+8,8), (base+16,4).
  - Expect 20 fifo_wr_en pulses with data matching mem_rdata in order.
  - Expect one frame_done, then busy=0.
- Backpressure: fifo_level=FIFO_DEPTH-5, BURST_LEN=8.
  - No mem_req while the level stays there.
  - Lower the level to FIFO_DEPTH-8: mem_req asserts on the next cycle.
- Restart in DATA: frame_start after beat 3 of an 8-beat burst.
  - Beats 4-8 produce no writes.
  - Then fifo_flush=1 for one cycle, and the next mem_addr equals the new fb_base.
- Restart in REQ: mem_req is 0 the cycle after frame_start, fifo_flush follows, no frame_done.
- Overrun: fifo_full=1 during one rvalid.
  - overrun_err=1 and held.
  - Cleared by the next frame_start.
- Wrap and reset:
  - fb_base=2^ADDR_W-4, BURST_LEN=8: second mem_addr is 4.
  - Assert rst_n=0 mid-DATA: all outputs 0 asynchronously, state IDLE.
